fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between the global-prediction PC generator and the decode stage. Each fetched instruction is stored as one entry: its PC, the instruction word, and the prediction bits (`PC_taken`, BTB `hit`). Decode later needs these bits to detect mispredictions. The queue absorbs decode stalls, and it discards all in-flight entries when the predictor or execute stage redirects the PC (correction, first-time taken branch, jump, exception or mret).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2.
- `XLEN`, default 32: PC and instruction width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset. Assertion immediately clears all state; release is synchronous to `clk`.
- `flush` in 1: redirect. Driven by the OR of `Wrong`, `first_and_Pcsrc`, `ID_EX_Jump`, `exception_sig` and `mret_sig`.
- `in_valid` in 1: a fetched entry is presented.
- `in_ready` out 1: the queue can accept an entry.
- `in_pc` in XLEN: PC of the fetched instruction.
- `in_instr` in XLEN: instruction word.
- `in_pred_taken` in 1: predictor `PC_taken` for this PC.
- `in_btb_hit` in 1: BTB `hit` for this PC.
- `out_valid` out 1: the head entry is available.
- `out_ready` in 1: decode accepts the head entry.
- `out_pc`, `out_instr` out XLEN: head entry fields.
- `out_pred_taken`, `out_btb_hit` out 1: head entry fields.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Circular buffer with read pointer `rd_ptr`, write pointer `wr_ptr` (both $clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
- Push occurs when `in_valid && in_ready && !flush`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop occurs when `out_valid && out_ready && !flush`. Then `rd_ptr` increments.
- Output flags:
  - `in_ready = (count != DEPTH)`, derived from registered state only. There is no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - The out fields show the entry at `rd_ptr`. When `out_valid=0` they hold stale data, which must be ignored.
- Simultaneous push and pop: `count` is unchanged and FIFO order is preserved. At `count==DEPTH` a push is impossible (`in_ready=0`), even if a pop occurs that cycle.
- Flush has priority over push and pop:
  - Next state: `count=0`, `rd_ptr=wr_ptr=0`.
  - An entry presented during the flush cycle is dropped.
  - A handshake at the output during the flush cycle is not a pop. Decode is flushed by the same signal.
- Reset, at any time including mid-stream:
  - `count=0` and both pointers 0.
  - Outputs: `out_valid=0`, `in_ready=1`, `count=0`, all out fields 0.
  - Storage contents are don't-care.
- `count` never exceeds DEPTH and never underflows. Pushing when full and popping when empty are ignored.

## Timing
- Base latency: an entry pushed in cycle N is visible at the output in cycle N+1.
- Throughput: one push and one pop per cycle.
- A flush asserted in cycle N gives `out_valid=0` and `in_ready=1` in cycle N+1.
- The redirected PC from the predictor may be pushed in N+1.
- All outputs are registered-derived, except the bypass path (see Configuration).

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: the queue gains a zero-latency fall-through path.
  - Condition: `count==0 && in_valid && out_ready && !flush`.
  - The in fields drive the out fields in the same cycle and the entry is not stored. `count` stays 0.
  - `out_valid = (count!=0) || in_valid`.
- Not defined: no combinational path from in to out. The minimum latency is 1 cycle.

## Structure
- Shared package `fetch_pkg` holds:
  - `fetch_entry_t`: a struct of pc, instr, pred_taken and btb_hit.
  - Default `XLEN`, `FQ_DEPTH`.
- One sub-module, `fq_storage`: a DEPTH×`fetch_entry_t` register array with one write port and one asynchronous read port.
- The queue top owns the pointers, counter, flush and bypass logic.

## Test plan
1. Reset: `reset=0` mid-stream with `count=3`, then release → immediately `out_valid=0`, `in_ready=1`, `count=0`. The next pushed PC (0x200) is the first output.
2. Fill: `out_ready=0`, push PCs 0x0, 0x4, 0x8, 0xC → `count=4`, `in_ready=0`. PC 0x10 is held off. Then `out_ready=1` → outputs 0x0, 0x4, 0x8, 0xC, 0x10 in order.
3. Concurrent push and pop at `count=2`, pushing PC 0x20 with pred_taken=1 and btb_hit=1 → `count` stays 2, and 0x20 emerges with both bits set.
4. Flush at `count=3` with `in_valid=1` and PC 0x40 → next cycle `count=0`, `out_valid=0`. Then pushing 0x80 → next output is 0x80 (0x40 is never seen).
5. Wrap: stream 10 sequential PCs 0x0–0x24 with random `out_ready` → all 10 out in order, and `count` ≤ 4 throughout.
6. Bypass: queue empty, `in_valid=1`, PC 0x100, `out_ready=1` → with `FETCH_QUEUE_BYPASS_EN`, `out_pc=0x100` in the same cycle and `count` stays 0. Without the macro, `out_pc=0x100` appears the next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch queue.
// Optional build macro used by fetch_queue: FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

  localparam int unsigned FQ_XLEN  = 32;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               pred_taken;
    logic               btb_hit;
  } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry register array for the fetch queue: one write port, one asynchronous read port.
// Cleared on reset so the head fields read zero straight out of reset.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = FQ_DEPTH,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the PC generator and decode; flush drops all in-flight entries.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency fall-through path when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned XLEN  = FQ_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  input  logic                   in_pred_taken,
  input  logic                   in_btb_hit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  output logic                   out_pred_taken,
  output logic                   out_btb_hit,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
    logic            btb_hit;
  } entry_t;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  entry_t        wr_entry, rd_entry, head;
  logic          empty, full, push, pop, bypass;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL);
  assign wr_entry = '{pc: in_pc, instr: in_instr, pred_taken: in_pred_taken, btb_hit: in_btb_hit};

`ifdef FETCH_QUEUE_BYPASS_EN
  // An entry handed straight to decode is never stored.
  assign bypass    = empty && in_valid && out_ready && !flush;
  assign out_valid = !empty || in_valid;
  assign head      = empty ? wr_entry : rd_entry;
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty;
  assign head      = rd_entry;
`endif

  assign push     = in_valid && !full && !flush && !bypass;
  assign pop      = !empty && out_ready && !flush;
  assign in_ready = !full;
  assign count    = cnt;

  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_pred_taken = head.pred_taken;
  assign out_btb_hit    = head.btb_hit;

  fq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
